// File: rtl/sar_conv_scheduler_pkg.sv
//==================================================================
// sar_conv_scheduler_pkg -- shared types for the SAR scan sequencer, rev 1.0
//==================================================================
`default_nettype none

package sar_conv_scheduler_pkg;

  localparam int SAR_RES_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_OUTPUT = 3'd5
  } state_t;

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_conv_scheduler_rr_picker.sv
//==================================================================
// sar_conv_scheduler_rr_picker -- round-robin channel chooser, rev 1.0
//==================================================================
`default_nettype none

module sar_conv_scheduler_rr_picker
  import sar_conv_scheduler_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         mask,
  input  logic                    advance,
  input  logic [$clog2(N_CH)-1:0] cur_ch,
  output logic [$clog2(N_CH)-1:0] next_ch,
  output logic                    found
);

  localparam int CH_W = $clog2(N_CH);

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] cand;

  // Scan from the farthest offset down so the closest set bit at/after rr_ptr wins.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = CH_W'(wrap_add(int'(rr_ptr), i, N_CH));
      if (mask[cand]) begin
        next_ch = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + CH_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sar_conv_scheduler.sv
//==================================================================
// sar_conv_scheduler -- multi-channel SAR scan, settle, average, timeout, rev 1.0
//==================================================================
`default_nettype none

module sar_conv_scheduler
  import sar_conv_scheduler_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int RES         = SAR_RES_DEFAULT,
  parameter int AVG_LOG2    = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic                    err_clr,
  input  logic                    adc_eoc,
  input  logic [RES-1:0]          adc_data,
  output logic                    adc_start,
  output logic [$clog2(N_CH)-1:0] mux_sel,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RES-1:0]          res_data,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CH_W   = $clog2(N_CH);
  localparam int ACC_W  = RES + AVG_LOG2;
  localparam int NSAMP  = 1 << AVG_LOG2;
  localparam int SAMP_W = AVG_LOG2 + 1;
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic              eoc_q;
  logic              eoc_rise;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [SAMP_W-1:0] samp;
  logic [SET_W-1:0]  settle_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              advance;
  logic [CH_W-1:0]   pick_ch;
  logic              pick_found;

  assign eoc_rise = adc_eoc & ~eoc_q;
  assign acc_sum  = acc + ACC_W'(adc_data);
  // The TIMEOUT_CYC-th WAIT cycle is the last one in which an EOC edge is accepted.
  assign tmo_hit  = (state == ST_WAIT) && !eoc_rise && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign advance  = tmo_hit || ((state == ST_OUTPUT) && res_ready);
  assign busy     = (state != ST_IDLE);

  sar_conv_scheduler_rr_picker #(
    .N_CH (N_CH)
  ) u_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .mask    (ch_mask),
    .advance (advance),
    .cur_ch  (mux_sel),
    .next_ch (pick_ch),
    .found   (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      eoc_q       <= 1'b0;
      mux_sel     <= '0;
      adc_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_ch      <= '0;
      timeout_err <= 1'b0;
      acc         <= '0;
      samp        <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
    end else begin
      eoc_q     <= adc_eoc;
      adc_start <= 1'b0;
      if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (enable && (ch_mask != '0)) begin
            state <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (!enable || !pick_found) begin
            state <= ST_IDLE;
          end else begin
            mux_sel    <= pick_ch;
            acc        <= '0;
            samp       <= '0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            settle_cnt <= '0;
            adc_start  <= 1'b1;
            state      <= ST_START;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end

        ST_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (eoc_rise) begin
            acc <= acc_sum;
            if (samp == SAMP_W'(NSAMP - 1)) begin
              res_data  <= acc_sum[ACC_W-1:AVG_LOG2];
              res_ch    <= mux_sel;
              res_valid <= 1'b1;
              state     <= ST_OUTPUT;
            end else begin
              samp  <= samp + SAMP_W'(1);
              state <= ST_SETTLE;
            end
          end else if (tmo_hit) begin
            // Placed after the err_clr clear so a same-cycle timeout keeps the flag set.
            timeout_err <= 1'b1;
            state       <= ST_SELECT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_SELECT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_conv_scheduler.sv
//==================================================================
// tb_sar_conv_scheduler -- randomized scoreboard bench for the SAR sequencer, rev 1.0
//==================================================================
`default_nettype none

module tb_sar_conv_scheduler;

  localparam int N_CH        = 4;
  localparam int RES         = 8;
  localparam int AVG_LOG2    = 2;
  localparam int SETTLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 32;
  localparam int NSAMP       = 1 << AVG_LOG2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N_CH-1:0] ch_mask = '0;
  logic            err_clr = 1'b0;
  logic            adc_eoc = 1'b0;
  logic [RES-1:0]  adc_data = '0;
  logic            res_ready = 1'b0;
  logic            adc_start;
  logic [1:0]      mux_sel;
  logic            res_valid;
  logic [RES-1:0]  res_data;
  logic [1:0]      res_ch;
  logic            busy;
  logic            timeout_err;

  sar_conv_scheduler #(
    .N_CH(N_CH), .RES(RES), .AVG_LOG2(AVG_LOG2),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .err_clr(err_clr), .adc_eoc(adc_eoc), .adc_data(adc_data),
    .adc_start(adc_start), .mux_sel(mux_sel), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ch(res_ch),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   compared   = 0;
  int   mismatched = 0;
  int   rr         = 0;
  int   ready_mode = 1;   // 0: hold low, 1: random, 2: always high
  bit   eoc_high   = 1'b0;
  bit   held       = 1'b0;
  int   hd, hc;
  logic [RES-1:0] fixed_vals [NSAMP] = '{8'h10, 8'h12, 8'h14, 8'h16};

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Reference channel choice: first enabled channel at or after the pointer, modulo N_CH.
  function automatic int pick(input int m, input int p);
    for (int i = 0; i < N_CH; i++) begin
      if (((m >> ((p + i) % N_CH)) & 1) != 0) return (p + i) % N_CH;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = ($urandom_range(0, 3) != 0);
        default: res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks holding while stalled.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (held) begin
        check("hold_data", int'(res_data), hd);
        check("hold_ch", int'(res_ch), hc);
      end
      check("no_start_while_valid", int'(adc_start), 0);
      if (res_ready) begin
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res_ch", int'(res_ch), e.ch);
          check("res_data", int'(res_data), e.data);
        end
        held = 1'b0;
      end else if (!held) begin
        held = 1'b1;
        hd   = int'(res_data);
        hc   = int'(res_ch);
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL start_wait: adc_start not seen within 300 cycles at %0t", $time);
    end
  endtask

  // ADC side of one conversion; entered at the negedge where adc_start was seen.
  task automatic deliver(input logic [RES-1:0] v, input bit leave_high);
    if (eoc_high) begin
      @(posedge clk); #1 adc_data = RES'($urandom);
      @(posedge clk); #1 adc_eoc = 1'b0;
    end
    repeat ($urandom_range(0, 8)) @(posedge clk);
    @(posedge clk); #1 adc_eoc = 1'b1; adc_data = v;
    @(posedge clk); #1 adc_data = RES'($urandom); adc_eoc = leave_high; eoc_high = leave_high;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (8) begin
      @(negedge clk);
      check("idle_busy", int'(busy), 0);
      check("idle_no_start", int'(adc_start), 0);
    end
  endtask

  task automatic run_channel(input bit fixed, input bit inject_to, input bit stall,
                             input logic [N_CH-1:0] next_mask, input bit drop_enable);
    int ch;
    int sum;
    bit ok;
    logic [RES-1:0] v;
    ch  = pick(int'(ch_mask), rr);
    sum = 0;
    for (int s = 0; s < NSAMP; s++) begin
      wait_start(ok);
      if (!ok) return;
      check("mux_sel", int'(mux_sel), ch);
      if (s == 0) begin
        ch_mask = next_mask;
        if (drop_enable) enable = 1'b0;
      end
      if (inject_to && s == NSAMP / 2) begin
        adc_eoc  = 1'b0;
        eoc_high = 1'b0;
        repeat (TIMEOUT_CYC) @(negedge clk);
        check("timeout_not_early", int'(timeout_err), 0);
        @(negedge clk);
        check("timeout_set", int'(timeout_err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", int'(timeout_err), 0);
        rr = (ch + 1) % N_CH;
        return;
      end
      v = fixed ? fixed_vals[s] : RES'($urandom_range(0, 255));
      if (s == NSAMP - 1) begin
        exp_q.push_back('{ch, (sum + int'(v)) >> AVG_LOG2});
        if (stall) ready_mode = 0;
      end
      deliver(v, fixed ? 1'b0 : ($urandom_range(0, 4) == 0));
      sum += int'(v);
    end
    rr = (ch + 1) % N_CH;
    if (stall) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (res_valid) break;
      end
      repeat (10) @(negedge clk);
      check("stall_valid_held", int'(res_valid), 1);
      ready_mode = 1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d compares", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int ch;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_adc_start", int'(adc_start), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_mux_sel", int'(mux_sel), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_ch", int'(res_ch), 0);
    rst_n = 1'b1;

    // Directed averaging case, then the next enabled channel must be ch2.
    ready_mode = 2;
    ch_mask    = 4'b0101;
    enable     = 1'b1;
    run_channel(1'b1, 1'b0, 1'b0, 4'b0101, 1'b0);
    ready_mode = 1;
    run_channel(1'b0, 1'b0, 1'b0, 4'b0101, 1'b0);
    run_channel(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
    run_channel(1'b0, 1'b1, 1'b0, 4'b1001, 1'b0);
    repeat (4) run_channel(1'b0, 1'b0, 1'b0, 4'b1001, 1'b0);

    run_channel(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    wait_idle();
    ch_mask = 4'b1111;
    run_channel(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1);
    wait_idle();
    enable = 1'b1;

    for (int it = 0; it < 40; it++) begin
      run_channel(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  (it % 3 == 0) ? N_CH'($urandom_range(1, 15)) : ch_mask, 1'b0);
    end

    // Asynchronous reset while waiting on a conversion.
    run_channel(1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
    ch = pick(int'(ch_mask), rr);
    wait_start(ok);
    check("pre_reset_mux", int'(mux_sel), ch);
    adc_eoc  = 1'b0;
    eoc_high = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_adc_start", int'(adc_start), 0);
    check("arst_res_valid", int'(res_valid), 0);
    check("arst_mux_sel", int'(mux_sel), 0);
    check("arst_res_data", int'(res_data), 0);
    check("arst_res_ch", int'(res_ch), 0);
    check("arst_timeout_err", int'(timeout_err), 0);
    exp_q.delete();
    rr      = 0;
    ch_mask = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_channel(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);
    run_channel(1'b0, 1'b0, 1'b0, 4'b1111, 1'b0);

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
